// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;
  localparam int CNT_W          = $clog2(DIVIDEND_W_DEF);
  // Widest operand the negate helper handles; callers zero/sign-extend into it.
  localparam int NEG_W          = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negate when neg is set; also serves as abs() when neg is the sign bit.
  // Low bits of the result are correct for any operand width up to NEG_W.
  function automatic logic [NEG_W-1:0] neg_if(input logic [NEG_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   partial_rem,
  input  logic [DIVISOR_W-1:0] divisor_abs,
  input  logic                 in_bit,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;

  // partial_rem < divisor_abs <= 2^(W-1), so the shifted value never reaches the top bit
  // and the top bit of trial is a clean borrow/sign flag.
  always_comb begin
    shifted  = {partial_rem, in_bit};
    trial    = shifted - {2'b00, divisor_abs};
    q_bit    = ~trial[DIVISOR_W+1];
    rem_next = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/div32s_seq.sv
// Sequential signed restoring divider: DIVIDEND_W / DIVISOR_W, one quotient bit per cycle,
// valid/ready on both sides, one operation in flight.
module div32s_seq
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] in_dividend,
  input  logic signed [DIVISOR_W-1:0]  in_divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DIVIDEND_W-1:0] out_quotient,
  output logic signed [DIVISOR_W-1:0]  out_remainder,
  output logic                         out_div_by_zero,
  output logic                         out_overflow
);

  localparam int CW = $clog2(DIVIDEND_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIVIDEND_W - 1);

  state_t state, state_nx;

  // Iteration registers: dvd_reg shifts the dividend out at the top and the quotient in at the bottom.
  logic [DIVIDEND_W-1:0] dvd_reg;
  logic [DIVISOR_W-1:0]  dsr_abs;
  logic [DIVISOR_W:0]    prem;
  logic [CW-1:0]         cnt;
  logic                  sign_q;
  logic                  sign_r;

  logic                  accept;
  logic                  is_dz;
  logic                  is_ovf;
  logic [DIVISOR_W:0]    prem_nx;
  logic                  qbit;

  logic [NEG_W-1:0]      abs_a_w;
  logic [NEG_W-1:0]      abs_b_w;
  logic [NEG_W-1:0]      q_fix_w;
  logic [NEG_W-1:0]      r_fix_w;
  logic                  unused_neg_bits;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_dz     = (in_divisor == '0);
  assign is_ovf    = (in_dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (in_divisor == '1);

  // Operand magnitudes on accept and sign-corrected results at the end of the iteration.
  always_comb begin
    abs_a_w = neg_if(NEG_W'(in_dividend), in_dividend[DIVIDEND_W-1]);
    abs_b_w = neg_if(NEG_W'(in_divisor), in_divisor[DIVISOR_W-1]);
    q_fix_w = neg_if(NEG_W'(dvd_reg), sign_q);
    r_fix_w = neg_if(NEG_W'(prem[DIVISOR_W-1:0]), sign_r && (prem != '0));
  end

  assign unused_neg_bits = ^{abs_a_w[NEG_W-1:DIVIDEND_W], abs_b_w[NEG_W-1:DIVISOR_W],
                             q_fix_w[NEG_W-1:DIVIDEND_W], r_fix_w[NEG_W-1:DIVISOR_W],
                             prem[DIVISOR_W]};

  div_restore_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .partial_rem(prem),
    .divisor_abs(dsr_abs),
    .in_bit     (dvd_reg[DIVIDEND_W-1]),
    .rem_next   (prem_nx),
    .q_bit      (qbit)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: special cases bypass the iteration and go straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (is_dz || is_ovf) ? DONE : CALC;
      CALC: if (cnt == LAST_CNT) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up into the output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      dvd_reg         <= '0;
      dsr_abs         <= '0;
      prem            <= '0;
      cnt             <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
      out_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_dz) begin
              out_quotient    <= '1;
              out_remainder   <= in_dividend[DIVISOR_W-1:0];
              out_div_by_zero <= 1'b1;
              out_overflow    <= 1'b0;
            end else if (is_ovf) begin
              out_quotient    <= in_dividend;
              out_remainder   <= '0;
              out_div_by_zero <= 1'b0;
              out_overflow    <= 1'b1;
            end else begin
              dvd_reg <= abs_a_w[DIVIDEND_W-1:0];
              dsr_abs <= abs_b_w[DIVISOR_W-1:0];
              sign_q  <= in_dividend[DIVIDEND_W-1] ^ in_divisor[DIVISOR_W-1];
              sign_r  <= in_dividend[DIVIDEND_W-1];
              prem    <= '0;
              cnt     <= '0;
            end
          end
        end
        CALC: begin
          dvd_reg <= {dvd_reg[DIVIDEND_W-2:0], qbit};
          prem    <= prem_nx;
          cnt     <= cnt + 1'b1;
        end
        FIX: begin
          out_quotient    <= q_fix_w[DIVIDEND_W-1:0];
          out_remainder   <= r_fix_w[DIVISOR_W-1:0];
          out_div_by_zero <= 1'b0;
          out_overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32s_seq.sv
// Randomized and directed bench for div32s_seq against a plain-arithmetic reference model.
module tb_div32s_seq;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_dividend;
  logic signed [15:0] in_divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_quotient;
  logic signed [15:0] out_remainder;
  logic               out_div_by_zero;
  logic               out_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  div32s_seq dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_div_by_zero(out_div_by_zero),
    .out_overflow   (out_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division with the two special cases handled explicitly.
  function automatic void model(input int a, input shortint b, output int q, output shortint r,
                                output bit dz, output bit ov);
    logic [31:0] au;
    au = a;
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q  = -1;
      r  = shortint'(au[15:0]);
      dz = 1;
    end else if (a == int'(32'h8000_0000) && b == -1) begin
      q  = a;
      r  = 0;
      ov = 1;
    end else begin
      q = int'(longint'(a) / longint'(b));
      r = shortint'(longint'(a) % longint'(b));
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction: accept, wait for result, compare, optionally stall, pop.
  task automatic do_op(input string tag, input int a, input shortint b, input int stall,
                       input bit junk_busy, input bit chk_lat, input bit inv);
    int      q;
    shortint r;
    bit      dz;
    bit      ov;
    int      lat;
    longint  lq;
    longint  lr;
    longint  lb;
    logic [47:0] snap;
    model(a, b, q, r, dz, ov);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    tick();
    lat = 1;
    in_valid = junk_busy;
    if (junk_busy) begin
      in_dividend = 32'h7777_1234;
      in_divisor  = 16'h0003;
    end
    while (!out_valid && lat < 100) begin
      if (lat == 5) chk({tag, "_busy_rdy"}, 64'(in_ready), 64'd0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (chk_lat) chk({tag, "_lat"}, 64'(lat), (dz || ov) ? 64'd1 : 64'd34);
    chk({tag, "_q"},  64'(out_quotient),  64'(q));
    chk({tag, "_r"},  64'(out_remainder), 64'(r));
    chk({tag, "_dz"}, 64'(out_div_by_zero), 64'(dz));
    chk({tag, "_ov"}, 64'(out_overflow), 64'(ov));
    if (inv && !dz && !ov) begin
      lq = longint'(out_quotient);
      lr = longint'(out_remainder);
      lb = longint'(b);
      chk({tag, "_inv"}, 64'(lq * lb + lr), 64'(longint'(a)));
      chk({tag, "_rmag"}, 64'(((lr < 0) ? -lr : lr) < ((lb < 0) ? -lb : lb)), 64'd1);
    end
    snap = {out_quotient, out_remainder};
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "_stall_dat"}, 64'({out_quotient, out_remainder}), 64'(snap));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_pop_vld"}, 64'(out_valid), 64'd0);
    chk({tag, "_pop_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int      a;
    shortint b;
    int      seen;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_q",   64'(out_quotient), 64'd0);
    chk("rst_r",   64'(out_remainder), 64'd0);
    chk("rst_flg", 64'({out_div_by_zero, out_overflow}), 64'd0);

    do_op("p100_7",  100,  7, 0, 0, 1, 1);
    do_op("n100_7",  -100, 7, 0, 0, 1, 1);
    do_op("p100_n7", 100, -7, 0, 0, 1, 1);
    do_op("n100_n7", -100, -7, 0, 0, 1, 1);
    do_op("dz",      32'h1234_5678, 16'sd0, 0, 0, 1, 0);
    do_op("ovf",     int'(32'h8000_0000), -16'sd1, 0, 0, 1, 0);
    do_op("minmin",  int'(32'h8000_0000), shortint'(16'h8000), 0, 0, 1, 1);
    do_op("min_p1",  int'(32'h8000_0000), 16'sd1, 0, 0, 1, 1);
    do_op("stall",   123456789, -321, 10, 1, 1, 1);
    do_op("b2b",     -987654, 1000, 0, 0, 1, 1);

    // Abort in the middle of the iteration.
    in_valid    = 1'b1;
    in_dividend = 100;
    in_divisor  = 7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rdy", 64'(in_ready), 64'd1);
    chk("abort_vld", 64'(out_valid), 64'd0);
    chk("abort_q",   64'(out_quotient), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_noout", 64'(seen), 64'd0);

    for (int n = 0; n < 1400; n++) begin
      a = int'($urandom);
      case ($urandom_range(0, 15))
        0:       b = 0;
        1:       begin a = int'(32'h8000_0000); b = -1; end
        2:       a = int'(32'h8000_0000);
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0:       b = shortint'($urandom_range(0, 15)) - 16'sd8;
        default: b = shortint'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) b = 0;
      do_op("rnd", a, b, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
